pipeline_layer_ctrl_regs: RTL and testbench
===========================================

Name: pipeline_layer_ctrl_regs

Overview:
Multi-layer successor to the single-foreground control register set. It parses a byte-oriented command stream from the SPI slave front end into per-layer staging registers. Staging values are committed atomically into the active registers at frame start, so the pipeline never sees a half-updated layer configuration mid-frame. It sits between the SPI byte receiver and one or more pipeline instances, which consume the flattened per-layer control buses.

Parameters:
LAYER_COUNT, 2, number of foreground layers (1..16).
PRECISION, 11, unsigned screen-coordinate width; offsets are PRECISION+1 bits signed.
TRANSPARENCY_PRECISION, 3, opacity is TRANSPARENCY_PRECISION+1 bits; full opacity = 2^TRANSPARENCY_PRECISION.

Ports:
clk  in  1  pipeline clock.
rst  in  1  asynchronous active-high reset.
rx_byte  in  8  received SPI byte.
rx_valid  in  1  one-cycle strobe; rx_byte is valid.
cmd_abort  in  1  pulse on SS deassert; discards a partial command.
frame_start  in  1  one-cycle pulse at the first pixel of a frame; commit point.
ctrl_overlay_mode  out  2*LAYER_COUNT  per layer: 0 off, 1 chroma key, 2 direct overlay.
ctrl_fg_scale  out  2*LAYER_COUNT  per-layer scale code.
ctrl_fg_offset_x  out  (PRECISION+1)*LAYER_COUNT  signed per-layer X offset.
ctrl_fg_offset_y  out  (PRECISION+1)*LAYER_COUNT  signed per-layer Y offset.
ctrl_fg_opacity  out  (TRANSPARENCY_PRECISION+1)*LAYER_COUNT  per-layer opacity.
ctrl_fg_clip_left / _right / _top / _bottom  out  PRECISION*LAYER_COUNT each  per-layer clip amounts.
commit_pending  out  1  staging differs from active; waiting for frame_start.
cmd_error  out  1  sticky error flag.

Behaviour:
- Layer i occupies bits [i*W +: W] of each bus.
- Reset, asynchronous: staging and active registers are both cleared to overlay 0, scale 0, offsets 0, clips 0, opacity 2^TRANSPARENCY_PRECISION. commit_pending=0, cmd_error=0, FSM=IDLE.
- Header byte: [7:4] field, [3:0] layer.
- Fields and payload bytes:
  - 0 mode: 1 byte, uses bits[1:0].
  - 1 scale: 1 byte, uses bits[1:0].
  - 2 offset_x, 3 offset_y: 2 bytes.
  - 4 opacity: 1 byte.
  - 5-8 clip left/right/top/bottom: 2 bytes.
  - 0xE clear error: 0 bytes.
  - 0xF commit now: 0 bytes.
- 2-byte payloads are big-endian {b0,b1} and truncated to the low PRECISION+1 bits (offset) or PRECISION bits (clip). Offsets are two's complement.
- Opacity byte > 2^TRANSPARENCY_PRECISION saturates to 2^TRANSPARENCY_PRECISION.
- FSM states: IDLE -> HDR_DONE -> PAYLOAD(count) -> IDLE.
  - IDLE: on rx_valid, latch field/layer. Zero-payload fields act at the next edge and stay in IDLE. Valid fields go to PAYLOAD with count 1 or 2.
  - Unknown field (9-0xD): cmd_error<=1, stay IDLE; the byte is consumed.
  - PAYLOAD: each rx_valid decrements count. On the last byte, staging is written at the next clock edge and commit_pending<=1; return to IDLE.
  - Layer >= LAYER_COUNT: payload is consumed, nothing is written, cmd_error<=1 at the last byte, commit_pending is unchanged.
- cmd_abort in any state: return to IDLE next edge, discard partial payload, no write. Abort and rx_valid in the same cycle: abort wins.
- Commit: frame_start with commit_pending=1 copies all staging to active at the next edge and clears commit_pending. With commit_pending=0, frame_start does nothing.
- Field 0xF: copies staging to active at the next edge regardless of frame_start and clears commit_pending. This applies to all layers; the layer nibble is ignored.
- Simultaneous final payload byte and frame_start: the commit uses the pre-write staging. The new write lands in staging, and commit_pending stays 1 for the next frame.
- Field 0xE with a simultaneous error source in the same cycle: the error set wins.
- Latency: last payload byte -> staging write 1 cycle; frame_start -> active outputs updated 1 cycle. Active outputs change only at commit edges.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - field-code constants (FIELD_MODE..FIELD_COMMIT);
  - overlay mode encodings;
  - the per-field payload-length function;
  - reset-value constants.
- One sub-module is natural: pipeline_layer_ctrl_bank. It holds the staging plus active register set for a single layer, with write-enable/field/data inputs and a commit input. It is instantiated LAYER_COUNT times in a generate loop; the parser FSM stays in the top level.

Test Plan:
- Reset with no commands: all layers read mode 0, offsets 0, opacity 8 (TRANSPARENCY_PRECISION=3), clips 0; commit_pending 0.
- Bytes 0x21,0xFF,0xF6 (offset_x layer 1 = -10) -> staging written, commit_pending 1, active unchanged. After frame_start pulse, next cycle layer-1 offset_x = 12'hFF6 (-10) and commit_pending 0.
- Bytes 0x40,0x20 -> opacity saturates to 8. Bytes 0x40,0x03 then 0xF0 -> layer 0 active opacity 3 one cycle after 0xF0, no frame_start needed.
- Bytes 0x51,0x00 then cmd_abort, then frame_start -> no change to clip_left, commit_pending stays 0.
- Header 0x05 with LAYER_COUNT=2 (layer 5) then 0x01 -> cmd_error 1, nothing written. Byte 0xE0 -> cmd_error 0. Header 0x90 -> cmd_error 1, FSM stays IDLE.
- Final payload byte of 0x00,0x02 coincident with frame_start -> active mode unchanged that frame, commit_pending 1. Next frame_start -> mode 2.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: field codes, overlay encodings, parser
// states, payload-length helper and reset values for layer ctrl.
package pipeline_ctrl_pkg;

  localparam logic [3:0] FIELD_MODE    = 4'h0;
  localparam logic [3:0] FIELD_SCALE   = 4'h1;
  localparam logic [3:0] FIELD_OFF_X   = 4'h2;
  localparam logic [3:0] FIELD_OFF_Y   = 4'h3;
  localparam logic [3:0] FIELD_OPACITY = 4'h4;
  localparam logic [3:0] FIELD_CLIP_L  = 4'h5;
  localparam logic [3:0] FIELD_CLIP_R  = 4'h6;
  localparam logic [3:0] FIELD_CLIP_T  = 4'h7;
  localparam logic [3:0] FIELD_CLIP_B  = 4'h8;
  localparam logic [3:0] FIELD_CLR_ERR = 4'hE;
  localparam logic [3:0] FIELD_COMMIT  = 4'hF;

  localparam logic [1:0] OVL_OFF    = 2'd0;
  localparam logic [1:0] OVL_CHROMA = 2'd1;
  localparam logic [1:0] OVL_DIRECT = 2'd2;

  localparam logic [1:0] RST_MODE  = OVL_OFF;
  localparam logic [1:0] RST_SCALE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR_DONE,
    ST_PAYLOAD
  } parse_state_t;

  // 0 means the header carries no payload (or is unknown).
  function automatic logic [1:0] payload_len(input logic [3:0] f);
    case (f)
      FIELD_MODE,
      FIELD_SCALE,
      FIELD_OPACITY: payload_len = 2'd1;
      FIELD_OFF_X,
      FIELD_OFF_Y,
      FIELD_CLIP_L,
      FIELD_CLIP_R,
      FIELD_CLIP_T,
      FIELD_CLIP_B:  payload_len = 2'd2;
      default:       payload_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_layer_ctrl_bank.sv
// pipeline_layer_ctrl_bank: staging + active regs for one layer.
// In: wr_en/wr_field/wr_data (staging write), commit. Out: active.
module pipeline_layer_ctrl_bank
  import pipeline_ctrl_pkg::*;
#(
  parameter int PRECISION              = 11,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [3:0]                      wr_field,
  input  logic [15:0]                     wr_data,
  input  logic                            commit,
  output logic [1:0]                      mode,
  output logic [1:0]                      scale,
  output logic [PRECISION:0]              offset_x,
  output logic [PRECISION:0]              offset_y,
  output logic [TRANSPARENCY_PRECISION:0] opacity,
  output logic [PRECISION-1:0]            clip_left,
  output logic [PRECISION-1:0]            clip_right,
  output logic [PRECISION-1:0]            clip_top,
  output logic [PRECISION-1:0]            clip_bottom
);

  localparam int OW = TRANSPARENCY_PRECISION + 1;
  localparam logic [OW-1:0] OPA_FULL =
    OW'(1 << TRANSPARENCY_PRECISION);

  logic [1:0]           s_mode;
  logic [1:0]           s_scale;
  logic [PRECISION:0]   s_off_x;
  logic [PRECISION:0]   s_off_y;
  logic [OW-1:0]        s_opa;
  logic [PRECISION-1:0] s_clip_l;
  logic [PRECISION-1:0] s_clip_r;
  logic [PRECISION-1:0] s_clip_t;
  logic [PRECISION-1:0] s_clip_b;
  logic [OW-1:0]        opa_sat;
  logic                 unused_hi;

  assign unused_hi = &{1'b0, wr_data[15:PRECISION+1]};

  always_comb begin
    opa_sat = OPA_FULL;
    if (int'(wr_data[7:0]) <= int'(OPA_FULL))
      opa_sat = OW'(wr_data[7:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_mode   <= RST_MODE;
      s_scale  <= RST_SCALE;
      s_off_x  <= '0;
      s_off_y  <= '0;
      s_opa    <= OPA_FULL;
      s_clip_l <= '0;
      s_clip_r <= '0;
      s_clip_t <= '0;
      s_clip_b <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        wr_field == FIELD_MODE:    s_mode   <= wr_data[1:0];
        wr_field == FIELD_SCALE:   s_scale  <= wr_data[1:0];
        wr_field == FIELD_OFF_X:   s_off_x  <= wr_data[PRECISION:0];
        wr_field == FIELD_OFF_Y:   s_off_y  <= wr_data[PRECISION:0];
        wr_field == FIELD_OPACITY: s_opa    <= opa_sat;
        wr_field == FIELD_CLIP_L:  s_clip_l <= wr_data[PRECISION-1:0];
        wr_field == FIELD_CLIP_R:  s_clip_r <= wr_data[PRECISION-1:0];
        wr_field == FIELD_CLIP_T:  s_clip_t <= wr_data[PRECISION-1:0];
        wr_field == FIELD_CLIP_B:  s_clip_b <= wr_data[PRECISION-1:0];
        default: ;
      endcase
    end
  end

  // Active copy reads staging before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode        <= RST_MODE;
      scale       <= RST_SCALE;
      offset_x    <= '0;
      offset_y    <= '0;
      opacity     <= OPA_FULL;
      clip_left   <= '0;
      clip_right  <= '0;
      clip_top    <= '0;
      clip_bottom <= '0;
    end else if (commit) begin
      mode        <= s_mode;
      scale       <= s_scale;
      offset_x    <= s_off_x;
      offset_y    <= s_off_y;
      opacity     <= s_opa;
      clip_left   <= s_clip_l;
      clip_right  <= s_clip_r;
      clip_top    <= s_clip_t;
      clip_bottom <= s_clip_b;
    end
  end

endmodule

// File: rtl/pipeline_layer_ctrl_regs.sv
// pipeline_layer_ctrl_regs: SPI command parser feeding per-layer
// banks; commits staging->active at frame_start or on 0xF.
module pipeline_layer_ctrl_regs
  import pipeline_ctrl_pkg::*;
#(
  parameter int LAYER_COUNT            = 2,
  parameter int PRECISION              = 11,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] rx_byte,
  input  logic rx_valid,
  input  logic cmd_abort,
  input  logic frame_start,
  output logic [2*LAYER_COUNT-1:0] ctrl_overlay_mode,
  output logic [2*LAYER_COUNT-1:0] ctrl_fg_scale,
  output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_x,
  output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_y,
  output logic [(TRANSPARENCY_PRECISION+1)*LAYER_COUNT-1:0]
               ctrl_fg_opacity,
  output logic [PRECISION*LAYER_COUNT-1:0] ctrl_fg_clip_left,
  output logic [PRECISION*LAYER_COUNT-1:0] ctrl_fg_clip_right,
  output logic [PRECISION*LAYER_COUNT-1:0] ctrl_fg_clip_top,
  output logic [PRECISION*LAYER_COUNT-1:0] ctrl_fg_clip_bottom,
  output logic commit_pending,
  output logic cmd_error
);

  localparam int PW = PRECISION + 1;
  localparam int OW = TRANSPARENCY_PRECISION + 1;

  parse_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  field_q, field_d;
  logic [3:0]  layer_q, layer_d;
  logic [7:0]  b0_q, b0_d;
  logic        wr_fire;
  logic        commit_now;
  logic        err_set;
  logic        err_clr;
  logic        layer_ok;
  logic        commit;
  logic [15:0] wr_data;

  assign layer_ok = {1'b0, layer_q} < 5'(LAYER_COUNT);
  assign commit   = commit_now | (frame_start & commit_pending);
  assign wr_data  = (payload_len(field_q) == 2'd2) ?
                    {b0_q, rx_byte} : {8'd0, rx_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      field_q <= '0;
      layer_q <= '0;
      b0_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      field_q <= field_d;
      layer_q <= layer_d;
      b0_q    <= b0_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    field_d    = field_q;
    layer_d    = layer_q;
    b0_d       = b0_q;
    wr_fire    = 1'b0;
    commit_now = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          field_d = rx_byte[7:4];
          layer_d = rx_byte[3:0];
          if (rx_byte[7:4] == FIELD_COMMIT) begin
            commit_now = 1'b1;
          end else if (rx_byte[7:4] == FIELD_CLR_ERR) begin
            err_clr = 1'b1;
          end else if (payload_len(rx_byte[7:4]) == 2'd0) begin
            err_set = 1'b1;
          end else begin
            state_d = ST_HDR_DONE;
            cnt_d   = payload_len(rx_byte[7:4]);
          end
        end
        ST_HDR_DONE,
        ST_PAYLOAD: begin
          cnt_d = cnt_q - 2'd1;
          b0_d  = rx_byte;
          if (cnt_q == 2'd1) begin
            state_d = ST_IDLE;
            wr_fire = layer_ok;
            err_set = ~layer_ok;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A new write keeps pending set even across a same-edge commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      if (wr_fire)
        commit_pending <= 1'b1;
      else if (commit)
        commit_pending <= 1'b0;
      if (err_set)
        cmd_error <= 1'b1;
      else if (err_clr)
        cmd_error <= 1'b0;
    end
  end

  for (genvar i = 0; i < LAYER_COUNT; i++) begin : g_layer
    pipeline_layer_ctrl_bank #(
      .PRECISION              (PRECISION),
      .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_fire && (layer_q == 4'(i))),
      .wr_field    (field_q),
      .wr_data     (wr_data),
      .commit      (commit),
      .mode        (ctrl_overlay_mode[i*2 +: 2]),
      .scale       (ctrl_fg_scale[i*2 +: 2]),
      .offset_x    (ctrl_fg_offset_x[i*PW +: PW]),
      .offset_y    (ctrl_fg_offset_y[i*PW +: PW]),
      .opacity     (ctrl_fg_opacity[i*OW +: OW]),
      .clip_left   (ctrl_fg_clip_left[i*PRECISION +: PRECISION]),
      .clip_right  (ctrl_fg_clip_right[i*PRECISION +: PRECISION]),
      .clip_top    (ctrl_fg_clip_top[i*PRECISION +: PRECISION]),
      .clip_bottom (ctrl_fg_clip_bottom[i*PRECISION +: PRECISION])
    );
  end

endmodule

// File: tb/tb_pipeline_layer_ctrl_regs.sv
// tb_pipeline_layer_ctrl_regs: directed + random command streams
// checked every cycle against a queue-based command model.
module tb_pipeline_layer_ctrl_regs;

  localparam int NL = 2;
  localparam int P  = 11;
  localparam int TP = 3;
  localparam int PW = P + 1;
  localparam int OW = TP + 1;
  localparam int FULL = 1 << TP;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic cmd_abort;
  logic frame_start;
  logic [2*NL-1:0] ctrl_overlay_mode;
  logic [2*NL-1:0] ctrl_fg_scale;
  logic [PW*NL-1:0] ctrl_fg_offset_x;
  logic [PW*NL-1:0] ctrl_fg_offset_y;
  logic [OW*NL-1:0] ctrl_fg_opacity;
  logic [P*NL-1:0] ctrl_fg_clip_left;
  logic [P*NL-1:0] ctrl_fg_clip_right;
  logic [P*NL-1:0] ctrl_fg_clip_top;
  logic [P*NL-1:0] ctrl_fg_clip_bottom;
  logic commit_pending;
  logic cmd_error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_layer_ctrl_regs #(
    .LAYER_COUNT            (NL),
    .PRECISION              (P),
    .TRANSPARENCY_PRECISION (TP)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_byte             (rx_byte),
    .rx_valid            (rx_valid),
    .cmd_abort           (cmd_abort),
    .frame_start         (frame_start),
    .ctrl_overlay_mode   (ctrl_overlay_mode),
    .ctrl_fg_scale       (ctrl_fg_scale),
    .ctrl_fg_offset_x    (ctrl_fg_offset_x),
    .ctrl_fg_offset_y    (ctrl_fg_offset_y),
    .ctrl_fg_opacity     (ctrl_fg_opacity),
    .ctrl_fg_clip_left   (ctrl_fg_clip_left),
    .ctrl_fg_clip_right  (ctrl_fg_clip_right),
    .ctrl_fg_clip_top    (ctrl_fg_clip_top),
    .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
    .commit_pending      (commit_pending),
    .cmd_error           (cmd_error)
  );

  task automatic chk(input string name, input int idx,
                     input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, got, exp);
    end
  endtask

  // Model: per-layer field arrays indexed by field code 0..8.
  int stg[NL][9];
  int act[NL][9];
  bit m_pend;
  bit m_err;
  byte unsigned cur[$];

  function automatic int plen(input int f);
    if (f == 0 || f == 1 || f == 4) return 1;
    if (f == 2 || f == 3 || (f >= 5 && f <= 8)) return 2;
    return 0;
  endfunction

  function automatic int fit(input int f, input int v);
    if (f <= 1) return v % 4;
    if (f <= 3) return v % 4096;
    if (f == 4) return (v > FULL) ? FULL : v;
    return v % 2048;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit do_commit, do_wr, e_set, e_clr;
    int wl, wf, wv, f, n;
    if (rst) begin
      for (int l = 0; l < NL; l++)
        for (int k = 0; k < 9; k++) begin
          stg[l][k] = (k == 4) ? FULL : 0;
          act[l][k] = (k == 4) ? FULL : 0;
        end
      m_pend = 0;
      m_err = 0;
      cur.delete();
    end else begin
      do_commit = frame_start && m_pend;
      do_wr = 0;
      e_set = 0;
      e_clr = 0;
      wl = 0;
      wf = 0;
      wv = 0;
      if (cmd_abort) begin
        cur.delete();
      end else if (rx_valid) begin
        cur.push_back(rx_byte);
        f = int'(cur[0]) / 16;
        n = plen(f);
        if (cur.size() == 1 && f == 15) begin
          do_commit = 1;
          cur.delete();
        end else if (cur.size() == 1 && f == 14) begin
          e_clr = 1;
          cur.delete();
        end else if (n == 0) begin
          e_set = 1;
          cur.delete();
        end else if (cur.size() == n + 1) begin
          wl = int'(cur[0]) % 16;
          wf = f;
          wv = (n == 2) ? int'(cur[1]) * 256 + int'(cur[2])
                        : int'(cur[1]);
          if (wl < NL) do_wr = 1;
          else e_set = 1;
          cur.delete();
        end
      end
      if (do_commit)
        for (int l = 0; l < NL; l++)
          for (int k = 0; k < 9; k++) act[l][k] = stg[l][k];
      if (do_wr) stg[wl][wf] = fit(wf, wv);
      if (do_wr) m_pend = 1;
      else if (do_commit) m_pend = 0;
      if (e_set) m_err = 1;
      else if (e_clr) m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < NL; l++) begin
        chk("mode", l, int'(ctrl_overlay_mode[l*2 +: 2]), act[l][0]);
        chk("scale", l, int'(ctrl_fg_scale[l*2 +: 2]), act[l][1]);
        chk("off_x", l, int'(ctrl_fg_offset_x[l*PW +: PW]), act[l][2]);
        chk("off_y", l, int'(ctrl_fg_offset_y[l*PW +: PW]), act[l][3]);
        chk("opacity", l, int'(ctrl_fg_opacity[l*OW +: OW]), act[l][4]);
        chk("clip_l", l, int'(ctrl_fg_clip_left[l*P +: P]), act[l][5]);
        chk("clip_r", l, int'(ctrl_fg_clip_right[l*P +: P]), act[l][6]);
        chk("clip_t", l, int'(ctrl_fg_clip_top[l*P +: P]), act[l][7]);
        chk("clip_b", l, int'(ctrl_fg_clip_bottom[l*P +: P]), act[l][8]);
      end
      chk("pending", 0, int'(commit_pending), int'(m_pend));
      chk("error", 0, int'(cmd_error), int'(m_err));
    end
  end

  task automatic step(input logic v, input logic [7:0] b,
                      input logic ab, input logic fs);
    rx_valid = v;
    rx_byte = b;
    cmd_abort = ab;
    frame_start = fs;
    @(negedge clk);
    rx_valid = 1'b0;
    cmd_abort = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  byte unsigned gq[$];

  task automatic gen_cmd();
    int r = $urandom_range(0, 19);
    int l = $urandom_range(0, 2);
    int f;
    if ($urandom_range(0, 15) == 0) l = 15;
    if (r < 16) f = r % 9;
    else if (r == 16) f = 14;
    else if (r == 17) f = 15;
    else f = $urandom_range(9, 13);
    gq.push_back(8'(f * 16 + l));
    for (int k = 0; k < plen(f); k++)
      gq.push_back((f == 4) ? 8'($urandom_range(0, 12))
                            : 8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic v;
    logic [7:0] b;
    rst = 1'b1;
    rx_byte = 8'h00;
    rx_valid = 1'b0;
    cmd_abort = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", 0, int'(ctrl_overlay_mode), 0);
    chk("rst_opacity", 0, int'(ctrl_fg_opacity), 'h88);
    chk("rst_off_x", 0, int'(ctrl_fg_offset_x), 0);
    chk("rst_clip_b", 0, int'(ctrl_fg_clip_bottom), 0);
    chk("rst_pending", 0, int'(commit_pending), 0);

    send(8'h21); send(8'hFF); send(8'hF6);
    chk("stg_pending", 0, int'(commit_pending), 1);
    chk("stg_off_x_l1", 1, int'(ctrl_fg_offset_x[PW +: PW]), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("cmt_off_x_l1", 1, int'(ctrl_fg_offset_x[PW +: PW]), 'hFF6);
    chk("cmt_pending", 0, int'(commit_pending), 0);

    send(8'h40); send(8'h20);
    send(8'h40); send(8'h03); send(8'hF0);
    chk("now_opacity_l0", 0, int'(ctrl_fg_opacity[0 +: OW]), 3);
    chk("now_pending", 0, int'(commit_pending), 0);

    send(8'h51); send(8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("abort_clip_l1", 1, int'(ctrl_fg_clip_left[P +: P]), 0);
    chk("abort_pending", 0, int'(commit_pending), 0);

    send(8'h05); send(8'h01);
    chk("badlayer_err", 0, int'(cmd_error), 1);
    chk("badlayer_pend", 0, int'(commit_pending), 0);
    send(8'hE0);
    chk("clr_err", 0, int'(cmd_error), 0);
    send(8'h90);
    chk("unk_err", 0, int'(cmd_error), 1);

    send(8'h10); send(8'h01);
    send(8'h00);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    chk("coin_mode_l0", 0, int'(ctrl_overlay_mode[1:0]), 0);
    chk("coin_scale_l0", 0, int'(ctrl_fg_scale[1:0]), 1);
    chk("coin_pending", 0, int'(commit_pending), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("next_mode_l0", 0, int'(ctrl_overlay_mode[1:0]), 2);
    chk("next_pending", 0, int'(commit_pending), 0);

    repeat (4000) begin
      if (gq.size() == 0) gen_cmd();
      v = ($urandom_range(0, 3) != 0);
      b = 8'h00;
      if (v) b = gq.pop_front();
      step(v, b, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) == 0);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
